axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_pkg.sv | 34 +++
 rtl/axi_beat_addr.sv | 35 +++
 rtl/axi_mem_slave.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared encodings, widths and FSM state types for the AXI memory slave.
package axi_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Severity order DECERR > SLVERR > OKAY matches the numeric encoding.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_beat_addr.sv
// Beat address generation: FIXED/INCR address, range test and word index.
module axi_beat_addr
    import axi_pkg::*;
#(
    parameter int               DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE = 32'h8000_0000,
    parameter int               AW    = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [1:0]        burst,
    input  logic [7:0]        beat,
    output logic              in_range,
    output logic [AW-1:0]     word_idx
);

    logic [ADDR_W-1:0] aligned_s;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] off_s;
    logic [ADDR_W-1:0] word_off_s;

    // Beat address (low three bits dropped, INCR wraps at 2^32) and its word offset.
    always_comb begin
        aligned_s = start_addr & 32'hFFFF_FFF8;
        if (burst == BURST_INCR) begin
            addr_s = aligned_s + {21'd0, beat, 3'b000};
        end else begin
            addr_s = aligned_s;
        end
        off_s      = addr_s - BASE;
        word_off_s = off_s >> 3;
        in_range   = (addr_s >= BASE) && (word_off_s < 32'(DEPTH));
        word_idx   = word_off_s[AW-1:0];
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI memory slave: independent read and write FSMs over one byte-enabled 64-bit memory.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int                DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
    parameter int                RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    input  logic [1:0]        arburst,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    output logic              rlast,
    input  logic              rready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    input  logic [1:0]        awburst,
    input  logic [7:0]        awlen,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    r_state_e          r_state_r;
    logic [ADDR_W-1:0] ar_addr_r;
    logic [1:0]        ar_burst_r;
    logic [7:0]        ar_len_r;
    logic [2:0]        ar_size_r;
    logic [7:0]        r_beat_r;
    logic [3:0]        r_cnt_r;
    logic [7:0]        r_sel_s;
    logic              r_err_s;
    logic              r_in_range_s;
    logic [AW-1:0]     r_idx_s;
    logic [DATA_W-1:0] r_data_s;
    logic [1:0]        r_resp_s;

    w_state_e          w_state_r;
    logic [ADDR_W-1:0] aw_addr_r;
    logic [1:0]        aw_burst_r;
    logic [7:0]        aw_len_r;
    logic [7:0]        w_beat_r;
    logic [1:0]        w_acc_r;
    logic              w_in_range_s;
    logic [AW-1:0]     w_idx_s;
    logic              w_fire_s;
    logic              w_last_beat_s;
    logic [1:0]        w_beat_resp_s;
    logic [1:0]        w_acc_next_s;
    logic              mem_we_s;

    axi_beat_addr #(.DEPTH(DEPTH), .BASE(BASE), .AW(AW)) u_rd_addr (
        .start_addr (ar_addr_r),
        .burst      (ar_burst_r),
        .beat       (r_sel_s),
        .in_range   (r_in_range_s),
        .word_idx   (r_idx_s)
    );

    axi_beat_addr #(.DEPTH(DEPTH), .BASE(BASE), .AW(AW)) u_wr_addr (
        .start_addr (aw_addr_r),
        .burst      (aw_burst_r),
        .beat       (w_beat_r),
        .in_range   (w_in_range_s),
        .word_idx   (w_idx_s)
    );

    // Select the beat to load next (beat 0 from R_WAIT, following beat in R_DATA) and flag illegal bursts.
    always_comb begin
        if (r_state_r == R_DATA) begin
            r_sel_s = r_beat_r + 8'd1;
        end else begin
            r_sel_s = 8'd0;
        end
        r_err_s = ar_burst_r[1] || (ar_size_r > 3'd3);
    end

    // Data and response for the beat being loaded; memory is read before this edge's write lands.
    always_comb begin
        if (r_err_s) begin
            r_data_s = 64'd0;
            r_resp_s = RESP_SLVERR;
        end else if (!r_in_range_s) begin
            r_data_s = 64'd0;
            r_resp_s = RESP_DECERR;
        end else begin
            r_data_s = mem[r_idx_s];
            r_resp_s = RESP_OKAY;
        end
    end

    // Read channel FSM with registered handshake and data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r  <= R_IDLE;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rlast      <= 1'b0;
            rdata      <= 64'd0;
            rresp      <= RESP_OKAY;
            ar_addr_r  <= 32'd0;
            ar_burst_r <= 2'b00;
            ar_len_r   <= 8'd0;
            ar_size_r  <= 3'd0;
            r_beat_r   <= 8'd0;
            r_cnt_r    <= 4'd0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (arready && arvalid) begin
                        ar_addr_r  <= araddr;
                        ar_burst_r <= arburst;
                        ar_len_r   <= arlen;
                        ar_size_r  <= arsize;
                        r_beat_r   <= 8'd0;
                        r_cnt_r    <= 4'(RD_LAT - 1);
                        arready    <= 1'b0;
                        r_state_r  <= R_WAIT;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_r == 4'd0) begin
                        rdata     <= r_data_s;
                        rresp     <= r_resp_s;
                        rlast     <= (r_sel_s == ar_len_r);
                        r_beat_r  <= r_sel_s;
                        rvalid    <= 1'b1;
                        r_state_r <= R_DATA;
                    end else begin
                        r_cnt_r <= r_cnt_r - 4'd1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid    <= 1'b0;
                            rlast     <= 1'b0;
                            arready   <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rdata    <= r_data_s;
                            rresp    <= r_resp_s;
                            rlast    <= (r_sel_s == ar_len_r);
                            r_beat_r <= r_sel_s;
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    // Per-beat write response, wlast consistency and memory write enable.
    always_comb begin
        w_fire_s      = (w_state_r == W_DATA) && wvalid && wready;
        w_last_beat_s = (w_beat_r == aw_len_r);
        if (aw_burst_r[1]) begin
            w_beat_resp_s = RESP_SLVERR;
        end else if (!w_in_range_s) begin
            w_beat_resp_s = RESP_DECERR;
        end else begin
            w_beat_resp_s = RESP_OKAY;
        end
        if (wlast != w_last_beat_s) begin
            w_acc_next_s = worst_resp(w_acc_r, worst_resp(w_beat_resp_s, RESP_SLVERR));
        end else begin
            w_acc_next_s = worst_resp(w_acc_r, w_beat_resp_s);
        end
        mem_we_s = w_fire_s && !rst && !aw_burst_r[1] && w_in_range_s;
    end

    // Write channel FSM; burst length comes from awlen, wlast only feeds the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r  <= W_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            aw_addr_r  <= 32'd0;
            aw_burst_r <= 2'b00;
            aw_len_r   <= 8'd0;
            w_beat_r   <= 8'd0;
            w_acc_r    <= RESP_OKAY;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (awready && awvalid) begin
                        aw_addr_r  <= awaddr;
                        aw_burst_r <= awburst;
                        aw_len_r   <= awlen;
                        w_beat_r   <= 8'd0;
                        w_acc_r    <= RESP_OKAY;
                        awready    <= 1'b0;
                        wready     <= 1'b1;
                        w_state_r  <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire_s) begin
                        w_acc_r <= w_acc_next_s;
                        if (w_last_beat_s) begin
                            wready    <= 1'b0;
                            bvalid    <= 1'b1;
                            bresp     <= w_acc_next_s;
                            w_state_r <= W_RESP;
                        end else begin
                            w_beat_r <= w_beat_r + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        bresp     <= RESP_OKAY;
                        awready   <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (mem_we_s && wstrb[b]) begin
                mem[w_idx_s][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed bursts against a transaction-level memory model.
module tb_axi_mem_slave;
    import axi_pkg::*;

    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          RD_LAT = 2;

    logic        clk, rst;
    logic [31:0] araddr;  logic arvalid; logic [1:0] arburst; logic [7:0] arlen; logic [2:0] arsize;
    logic        arready;
    logic [63:0] rdata;   logic [1:0] rresp; logic rvalid, rlast, rready;
    logic [31:0] awaddr;  logic awvalid; logic [1:0] awburst; logic [7:0] awlen; logic awready;
    logic [63:0] wdata;   logic [7:0] wstrb; logic wlast, wvalid, wready;
    logic [1:0]  bresp;   logic bvalid, bready;

    axi_mem_slave #(.DEPTH(DEPTH), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
        .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_r[$];
    logic [1:0]  exp_b[$];
    logic [63:0] got_q[$];
    logic [1:0]  got_rs[$];
    logic [1:0]  got_b;
    int          w_acc_n;
    logic [63:0] wd_q[$];
    logic [7:0]  ws_q[$];
    logic [63:0] mm [int];
    int          lat_k = -1;
    bit          ar_next = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] beat_addr(logic [31:0] a, logic [1:0] burst, int i);
        logic [31:0] al;
        al = a & 32'hFFFF_FFF8;
        return (burst == 2'b01) ? al + 32'(8 * i) : al;
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 32'(DEPTH));
    endfunction

    function automatic logic [1:0] wmax(logic [1:0] a, logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Expected beats of a read burst, from the current model memory.
    function automatic void model_read(logic [31:0] a, logic [1:0] burst, logic [7:0] len, logic [2:0] size);
        for (int i = 0; i <= int'(len); i++) begin
            beat_t       bt;
            logic [31:0] ba;
            ba = beat_addr(a, burst, i);
            bt.last = (i == int'(len));
            if (burst[1] || size > 3'd3) begin
                bt.data = 64'd0; bt.resp = 2'b10;
            end else if (!in_rng(ba)) begin
                bt.data = 64'd0; bt.resp = 2'b11;
            end else begin
                bt.data = mm.exists(int'((ba - BASE) >> 3)) ? mm[int'((ba - BASE) >> 3)] : 64'd0;
                bt.resp = 2'b00;
            end
            exp_r.push_back(bt);
        end
    endfunction

    // Apply a write burst to the model memory and queue its expected response.
    function automatic void model_write(logic [31:0] a, logic [1:0] burst, logic [7:0] len, int early);
        logic [1:0] w;
        w = burst[1] ? 2'b10 : 2'b00;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] ba;
            logic [63:0] old;
            bit          wl;
            int          k;
            wl = (early >= 0) ? (i == early) : (i == int'(len));
            ba = beat_addr(a, burst, i);
            if (wl != (i == int'(len))) w = wmax(w, 2'b10);
            if (!burst[1]) begin
                if (!in_rng(ba)) begin
                    w = wmax(w, 2'b11);
                end else begin
                    k   = int'((ba - BASE) >> 3);
                    old = mm.exists(k) ? mm[k] : 64'd0;
                    for (int b = 0; b < 8; b++) begin
                        if (ws_q[i][b]) old[b*8 +: 8] = wd_q[i][b*8 +: 8];
                    end
                    mm[k] = old;
                end
            end
        end
        exp_b.push_back(w);
    endfunction

    // Compare process: checks every meaningful output cycle against the model queues.
    always @(negedge clk) begin
        if (rst) begin
            lat_k   = -1;
            ar_next = 1'b0;
        end else begin
            if (ar_next) begin
                chk("arready_after_last", arready, 1);
                ar_next = 1'b0;
            end
            if (lat_k >= 0) begin
                lat_k++;
                if (lat_k <= RD_LAT) begin
                    chk("rvalid_early", rvalid, 0);
                end else begin
                    chk("rvalid_rise", rvalid, 1);
                    lat_k = -1;
                end
            end
            if (arvalid && arready) lat_k = 0;
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", rvalid, 0);
                end else begin
                    chk("rdata", rdata, exp_r[0].data);
                    chk("rresp", rresp, exp_r[0].resp);
                    chk("rlast", rlast, exp_r[0].last);
                    if (rready) begin
                        got_q.push_back(rdata);
                        got_rs.push_back(rresp);
                        if (rlast) ar_next = 1'b1;
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", bvalid, 0);
                end else begin
                    chk("bresp", bresp, exp_b[0]);
                    chk("awready_during_b", awready, 0);
                    if (bready) begin
                        got_b = bresp;
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue_ar(input logic [31:0] a, input logic [1:0] burst, input logic [7:0] len,
                            input logic [2:0] size);
        int n;
        got_q.delete(); got_rs.delete();
        araddr = a; arburst = burst; arlen = len; arsize = size; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        if (!arready) chk("ar_timeout", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] burst, input logic [7:0] len,
                           input logic [2:0] size, input bit toggle);
        int n;
        model_read(a, burst, len, size);
        issue_ar(a, burst, len, size);
        rready = toggle ? 1'b0 : 1'b1;
        n = 0;
        while (exp_r.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            if (toggle) rready = ~rready;
            n++;
        end
        if (exp_r.size() != 0) begin
            chk("r_timeout", 64'(exp_r.size()), 0);
            exp_r.delete();
        end
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] burst, input logic [7:0] len,
                            input int early, input int bdelay);
        int n;
        model_write(a, burst, len, early);
        awaddr = a; awburst = burst; awlen = len; awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        if (!awready) chk("aw_timeout", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        w_acc_n = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wd_q[i];
            wstrb  = ws_q[i];
            wlast  = (early >= 0) ? (i == early) : (i == int'(len));
            wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 50);
            if (!wready) begin
                chk("w_timeout", wready, 1);
                break;
            end
            @(posedge clk); #1;
            w_acc_n++;
        end
        wvalid = 1'b0; wlast = 1'b0;
        repeat (bdelay) @(posedge clk);
        #1;
        if (bdelay > 0) chk("bvalid_held", bvalid, 1);
        bready = 1'b1;
        n = 0;
        while (exp_b.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_b.size() != 0) begin
            chk("b_timeout", 64'(exp_b.size()), 0);
            exp_b.delete();
        end
        bready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        araddr = 32'd0; arvalid = 1'b0; arburst = 2'b00; arlen = 8'd0; arsize = 3'd0; rready = 1'b0;
        awaddr = 32'd0; awvalid = 1'b0; awburst = 2'b00; awlen = 8'd0;
        wdata = 64'd0; wstrb = 8'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", arready, 0); chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);   chk("rst_rlast", rlast, 0);     chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);     chk("rst_rresp", rresp, 0);     chk("rst_bresp", bresp, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("arready_still_low", arready, 0);
        @(negedge clk);
        chk("arready_first", arready, 1);
        chk("awready_first", awready, 1);
        @(posedge clk); #1;

        // INCR write 1..4 then read back
        wd_q = '{64'd1, 64'd2, 64'd3, 64'd4};
        ws_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_write(BASE, 2'b01, 8'd3, -1, 0);
        chk("incr_bresp", got_b, 2'b00);
        chk("incr_wbeats", 64'(w_acc_n), 4);
        do_read(BASE, 2'b01, 8'd3, 3'd3, 1'b0);
        chk("incr_nbeats", 64'(got_q.size()), 4);
        chk("incr_d0", got_q[0], 64'd1); chk("incr_d1", got_q[1], 64'd2);
        chk("incr_d2", got_q[2], 64'd3); chk("incr_d3", got_q[3], 64'd4);

        // Partial strobe
        wd_q = '{64'hFFFF_FFFF_FFFF_FFFF}; ws_q = '{8'hFF};
        do_write(BASE + 32'h10, 2'b01, 8'd0, -1, 0);
        wd_q = '{64'd0}; ws_q = '{8'h0F};
        do_write(BASE + 32'h10, 2'b01, 8'd0, -1, 0);
        do_read(BASE + 32'h10, 2'b01, 8'd0, 3'd3, 1'b0);
        chk("strobe_data", got_q[0], 64'hFFFF_FFFF_0000_0000);

        // Out of range at the top of memory and below BASE
        wd_q = '{64'hDEAD_BEEF_0123_4567}; ws_q = '{8'hFF};
        do_write(BASE + 32'(8 * DEPTH) - 32'd8, 2'b01, 8'd0, -1, 0);
        do_read(BASE + 32'(8 * DEPTH) - 32'd8, 2'b01, 8'd1, 3'd3, 1'b0);
        chk("oor_d0", got_q[0], 64'hDEAD_BEEF_0123_4567); chk("oor_r0", got_rs[0], 2'b00);
        chk("oor_d1", got_q[1], 64'd0);                  chk("oor_r1", got_rs[1], 2'b11);
        do_write(BASE - 32'd8, 2'b01, 8'd0, -1, 0);
        chk("oor_bresp", got_b, 2'b11);

        // Backpressure on both channels
        do_read(BASE, 2'b01, 8'd3, 3'd3, 1'b1);
        chk("bp_nbeats", 64'(got_q.size()), 4);
        chk("bp_d0", got_q[0], 64'd1); chk("bp_d3", got_q[3], 64'd4);
        wd_q = '{64'h77}; ws_q = '{8'hFF};
        do_write(BASE + 32'h20, 2'b01, 8'd0, -1, 5);
        chk("bp_bresp", got_b, 2'b00);

        // Protocol errors
        wd_q = '{64'h5555}; ws_q = '{8'hFF};
        do_write(BASE, 2'b10, 8'd0, -1, 0);
        chk("wrap_bresp", got_b, 2'b10);
        do_read(BASE, 2'b01, 8'd0, 3'd3, 1'b0);
        chk("wrap_nowrite", got_q[0], 64'd1);
        wd_q = '{64'hA1, 64'hA2, 64'hA3}; ws_q = '{8'hFF, 8'hFF, 8'hFF};
        do_write(BASE + 32'h40, 2'b01, 8'd2, 1, 0);
        chk("early_last_bresp", got_b, 2'b10);
        chk("early_last_beats", 64'(w_acc_n), 3);

        // FIXED burst and illegal read bursts/sizes
        wd_q = '{64'hA, 64'hB, 64'hC}; ws_q = '{8'hFF, 8'hFF, 8'hFF};
        do_write(BASE + 32'h80, 2'b00, 8'd2, -1, 0);
        do_read(BASE + 32'h80, 2'b00, 8'd1, 3'd3, 1'b0);
        chk("fixed_d0", got_q[0], 64'hC); chk("fixed_d1", got_q[1], 64'hC);
        do_read(BASE, 2'b11, 8'd1, 3'd3, 1'b0);
        chk("rsvd_resp", got_rs[0], 2'b10); chk("rsvd_data", got_q[0], 64'd0);
        do_read(BASE, 2'b01, 8'd0, 3'd4, 1'b0);
        chk("size_resp", got_rs[0], 2'b10);

        // Reset in the middle of an 8-beat read
        wd_q.delete(); ws_q.delete();
        for (int i = 0; i < 8; i++) begin
            wd_q.push_back(64'(i + 1) * 64'h1111);
            ws_q.push_back(8'hFF);
        end
        do_write(BASE + 32'h100, 2'b01, 8'd7, -1, 0);
        model_read(BASE + 32'h100, 2'b01, 8'd7, 3'd3);
        issue_ar(BASE + 32'h100, 2'b01, 8'd7, 3'd3);
        rready = 1'b1;
        n = 0;
        while (got_q.size() < 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_rst_beats", 64'(got_q.size()), 2);
        rst = 1'b1;
        exp_r.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rvalid", rvalid, 0); chk("midrst_rlast", rlast, 0); chk("midrst_arready", arready, 0);
        @(posedge clk); #1;
        rst = 1'b0; rready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_arready", arready, 1);
        @(posedge clk); #1;
        do_read(BASE + 32'h100, 2'b01, 8'd7, 3'd3, 1'b0);
        chk("post_rst_nbeats", 64'(got_q.size()), 8);
        chk("post_rst_d0", got_q[0], 64'h1111);
        chk("post_rst_d7", got_q[7], 64'h8888);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
